// File: rtl/seq_alu_mc.sv
// Registered ALU with valid/ready handshakes on both sides: single-cycle logic/add ops,
// WIDTH-iteration shift-add multiply and restoring divide, one operation in flight.
module seq_alu_mc #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_EQ   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_XNOR = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH[WIDTH-1:0];
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opd;     // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   hi;      // partial product high / running remainder
    logic [WIDTH-1:0]   lo;      // multiplier bits / dividend shifting into quotient
    logic               is_div;

    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   sc_res, sc_hi;
    logic               sc_carry, sc_err, sc_zero;

    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               needs_iter;

    assign in_ready   = (state == IDLE);
    assign needs_iter = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));

    // Single-cycle results, computed straight from the operands presented at accept.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b};
        diff_w   = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (opcode)
            OP_ADD:  {sc_carry, sc_res} = sum_w;
            OP_SUB:  {sc_carry, sc_res} = diff_w;
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = a;
                sc_err = 1'b1;
            end
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, a == b};
            OP_XOR:  sc_res = a ^ b;
            OP_XNOR: sc_res = ~(a ^ b);
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SHL:  sc_res = (b >= SHIFT_LIM) ? '0 : (a << b);
            OP_SHR:  sc_res = (b >= SHIFT_LIM) ? '0 : (a >> b);
            default: sc_err = 1'b1;
        endcase
        sc_zero = (sc_res == '0);
    end

    // One shift-add or restoring-divide step on the {hi, lo} pair.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        div_sh  = {hi, lo[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opd});
        div_sub = div_sh[WIDTH-1:0] - opd;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            opd       <= '0;
            hi        <= '0;
            lo        <= '0;
            is_div    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (needs_iter) begin
                            state  <= BUSY;
                            cnt    <= '0;
                            is_div <= (opcode == OP_DIV);
                            opd    <= (opcode == OP_DIV) ? b : a;
                            lo     <= (opcode == OP_DIV) ? a : b;
                            hi     <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            result_hi <= sc_hi;
                            zero      <= sc_zero;
                            carry     <= sc_carry;
                            err       <= sc_err;
                        end
                    end
                end
                BUSY: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + CNT_W'(1);
                    // The final step is written straight to the outputs to hit WIDTH+1 latency.
                    if (cnt == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= step_lo;
                        result_hi <= step_hi;
                        zero      <= is_div ? (step_lo == '0) : ({step_hi, step_lo} == '0);
                        carry     <= !is_div && (|step_hi);
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
